target_select_uart_tx: RTL and testbench

Serialises the 8-bit target-selection word (`{target[5:0], channel[1:0]}`) produced by the button-driven target selector onto a UART line to the host/robot controller. A frame is sent automatically whenever the word differs from the last word sent, and optionally re-sent on a heartbeat timer. It sits directly downstream of the target selector and drives the board's UART TX pin.

---
 rtl/target_select_uart_tx.sv | 139 +++++++++++++
 tb/tb_target_select_uart_tx.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/target_select_uart_tx.sv
// 8N1 UART transmitter for the target-selection word: sends a frame whenever the
// word changes from the last one sent, and optionally re-sends it on a heartbeat.
module target_select_uart_tx #(
    parameter int CLK_FREQ      = 100_000_000,
    parameter int BAUD          = 115200,
    parameter int REPEAT_CYCLES = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    output logic       sent
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int BCW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int RCW = (REPEAT_CYCLES > 0) ? $clog2(REPEAT_CYCLES + 1) : 1;
    localparam logic [BCW-1:0] BAUD_LAST = BCW'(CLKS_PER_BIT - 1);
    localparam logic [RCW-1:0] REP_LAST  = RCW'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam bit HB_EN = (REPEAT_CYCLES > 0);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e         state_q, state_d;
    logic [7:0]     shift_q, shift_d;
    logic [7:0]     last_sent_q, last_sent_d;
    logic [BCW-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [RCW-1:0] rep_cnt_q, rep_cnt_d;
    logic           tx_q, tx_d;
    logic           busy_q, busy_d;
    logic           sent_q, sent_d;

    logic baud_done;
    logic hb_expire;
    logic trigger;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        last_sent_d = last_sent_q;
        baud_cnt_d  = baud_cnt_q;
        bit_idx_d   = bit_idx_q;
        rep_cnt_d   = rep_cnt_q;

        baud_done = (baud_cnt_q == BAUD_LAST);
        hb_expire = HB_EN && (rep_cnt_q == REP_LAST);
        trigger   = (data_in != last_sent_q) || hb_expire;

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    shift_d     = data_in;
                    last_sent_d = data_in;
                    baud_cnt_d  = '0;
                    rep_cnt_d   = '0;
                    state_d     = START;
                end else if (HB_EN) begin
                    rep_cnt_d = rep_cnt_q + RCW'(1);
                end
            end
            START: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + BCW'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + BCW'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_cnt_d = '0;
                    state_d    = IDLE;
                end else begin
                    baud_cnt_d = baud_cnt_q + BCW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from next-state values so the line never glitches.
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[bit_idx_d];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
        sent_d = (state_d == STOP) && (baud_cnt_d == BAUD_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            last_sent_q <= '0;
            baud_cnt_q  <= '0;
            bit_idx_q   <= '0;
            rep_cnt_q   <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            sent_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            last_sent_q <= last_sent_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_idx_q   <= bit_idx_d;
            rep_cnt_q   <= rep_cnt_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            sent_q      <= sent_d;
        end
    end

    assign tx   = tx_q;
    assign busy = busy_q;
    assign sent = sent_q;

endmodule

// File: tb/tb_target_select_uart_tx.sv
// Directed bench for target_select_uart_tx: two instances (no heartbeat / heartbeat=200),
// a line decoder popping a scoreboard of expected bytes, and frame timing checks.
module tb_target_select_uart_tx;

    logic       clk;
    logic       rst_n [2];
    logic [7:0] din   [2];
    logic       tx    [2];
    logic       busy  [2];
    logic       sent  [2];

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb0[$];
    logic [7:0] sb1[$];

    target_select_uart_tx #(
        .CLK_FREQ     (1_000_000),
        .BAUD         (100_000),
        .REPEAT_CYCLES(0)
    ) dut0 (
        .clk    (clk),
        .rst_n  (rst_n[0]),
        .data_in(din[0]),
        .tx     (tx[0]),
        .busy   (busy[0]),
        .sent   (sent[0])
    );

    target_select_uart_tx #(
        .CLK_FREQ     (1_000_000),
        .BAUD         (100_000),
        .REPEAT_CYCLES(200)
    ) dut1 (
        .clk    (clk),
        .rst_n  (rst_n[1]),
        .data_in(din[1]),
        .tx     (tx[1]),
        .busy   (busy[1]),
        .sent   (sent[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line decoder: samples each bit mid-cell (cell = 10 clocks), pops the scoreboard at the stop bit.
    int         mcnt [2];
    bit         mact [2];
    logic [7:0] mbyte[2];
    logic [7:0] mexp;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst_n[d] !== 1'b1) begin
                mact[d] = 1'b0;
            end else if (!mact[d]) begin
                if (tx[d] === 1'b0) begin
                    mact[d] = 1'b1;
                    mcnt[d] = 0;
                end
            end else begin
                mcnt[d]++;
                if (mcnt[d] == 5) begin
                    chk($sformatf("dut%0d start_bit", d), 32'(tx[d]), 32'd0);
                end else if (mcnt[d] >= 15 && mcnt[d] <= 85 && (mcnt[d] - 15) % 10 == 0) begin
                    mbyte[d][(mcnt[d] - 15) / 10] = tx[d];
                end else if (mcnt[d] == 95) begin
                    chk($sformatf("dut%0d stop_bit", d), 32'(tx[d]), 32'd1);
                    if (d == 0) begin
                        chk("dut0 frame_expected", 32'(sb0.size() != 0), 32'd1);
                        if (sb0.size() != 0) begin
                            mexp = sb0.pop_front();
                            chk("dut0 frame_data", 32'(mbyte[d]), 32'(mexp));
                        end
                    end else begin
                        chk("dut1 frame_expected", 32'(sb1.size() != 0), 32'd1);
                        if (sb1.size() != 0) begin
                            mexp = sb1.pop_front();
                            chk("dut1 frame_data", 32'(mbyte[d]), 32'(mexp));
                        end
                    end
                    mact[d] = 1'b0;
                end
            end
        end
    end

    // Entered on a negedge with busy high (first frame cycle); leaves on first idle negedge.
    task automatic measure(input int d, output int nb, output int spos, output int nsent);
        nb    = 0;
        spos  = 0;
        nsent = 0;
        while (busy[d] === 1'b1 && nb < 300) begin
            nb++;
            if (sent[d] === 1'b1) begin
                nsent++;
                spos = nb;
            end
            @(negedge clk);
        end
    endtask

    // Counts idle negedges until busy rises (bounded by limit).
    task automatic idle_until_busy(input int d, input int limit, output int n);
        n = 0;
        while (busy[d] !== 1'b1 && n < limit) begin
            n++;
            @(negedge clk);
        end
    endtask

    int n, nb, spos, nsent, bad;

    initial begin
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        din[0]   = 8'h03;
        din[1]   = 8'h53;
        #1;
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("dut%0d reset_tx", d), 32'(tx[d]), 32'd1);
            chk($sformatf("dut%0d reset_busy", d), 32'(busy[d]), 32'd0);
            chk($sformatf("dut%0d reset_sent", d), 32'(sent[d]), 32'd0);
        end

        // Power-up word 8'h03 goes out right after reset release.
        sb0.push_back(8'h03);
        rst_n[0] = 1'b1;
        idle_until_busy(0, 50, n);
        chk("t1 start_latency", 32'(n), 32'd1);
        chk("t1 start_tx", 32'(tx[0]), 32'd0);
        measure(0, nb, spos, nsent);
        chk("t1 busy_len", 32'(nb), 32'd100);
        chk("t1 sent_pos", 32'(spos), 32'd100);
        chk("t1 sent_count", 32'(nsent), 32'd1);
        chk("t1 idle_tx", 32'(tx[0]), 32'd1);

        // Steady input with no heartbeat: line stays quiet.
        bad = 0;
        repeat (5000) begin
            if (tx[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
            @(negedge clk);
        end
        chk("t2 quiet_cycles", 32'(bad), 32'd0);

        // Two mid-frame changes: only the final value follows, after one idle cycle.
        din[0] = 8'hA5;
        sb0.push_back(8'hA5);
        idle_until_busy(0, 50, n);
        chk("t3 start_latency", 32'(n), 32'd1);
        repeat (20) @(negedge clk);
        din[0] = 8'h07;
        repeat (30) @(negedge clk);
        din[0] = 8'h0B;
        sb0.push_back(8'h0B);
        measure(0, nb, spos, nsent);
        chk("t3 busy_rest", 32'(nb), 32'd50);
        idle_until_busy(0, 50, n);
        chk("t3 gap", 32'(n), 32'd1);
        measure(0, nb, spos, nsent);
        chk("t3 busy_len", 32'(nb), 32'd100);
        chk("t3 sent_count", 32'(nsent), 32'd1);

        // Mid-frame change that reverts to the value being sent: nothing follows.
        din[0] = 8'h07;
        sb0.push_back(8'h07);
        idle_until_busy(0, 50, n);
        chk("t4 start_latency", 32'(n), 32'd1);
        repeat (30) @(negedge clk);
        din[0] = 8'h0B;
        repeat (30) @(negedge clk);
        din[0] = 8'h07;
        measure(0, nb, spos, nsent);
        chk("t4 busy_rest", 32'(nb), 32'd40);
        idle_until_busy(0, 300, n);
        chk("t4 no_refire", 32'(n), 32'd300);

        // Reset during bit 4 abandons the frame; release restarts it.
        din[0] = 8'h5C;
        idle_until_busy(0, 50, n);
        chk("t5 start_latency", 32'(n), 32'd1);
        repeat (54) @(negedge clk);
        rst_n[0] = 1'b0;
        #1;
        chk("t5 rst_tx", 32'(tx[0]), 32'd1);
        chk("t5 rst_busy", 32'(busy[0]), 32'd0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (sent[0] !== 1'b0 || busy[0] !== 1'b0 || tx[0] !== 1'b1) bad++;
        end
        chk("t5 rst_hold", 32'(bad), 32'd0);
        sb0.push_back(8'h5C);
        rst_n[0] = 1'b1;
        idle_until_busy(0, 50, n);
        chk("t5 restart_latency", 32'(n), 32'd1);
        measure(0, nb, spos, nsent);
        chk("t5 busy_len", 32'(nb), 32'd100);
        chk("t5 sent_count", 32'(nsent), 32'd1);

        // Heartbeat instance: REPEAT_CYCLES idle cycles between frames.
        sb1.push_back(8'h53);
        rst_n[1] = 1'b1;
        idle_until_busy(1, 50, n);
        chk("hb start_latency", 32'(n), 32'd1);
        measure(1, nb, spos, nsent);
        chk("hb busy_len", 32'(nb), 32'd100);
        sb1.push_back(8'h53);
        idle_until_busy(1, 1000, n);
        chk("hb idle_len", 32'(n), 32'd200);
        measure(1, nb, spos, nsent);
        chk("hb busy_len2", 32'(nb), 32'd100);
        chk("hb sent_count", 32'(nsent), 32'd1);

        // Change lands exactly on the expiry cycle: one frame, new value.
        repeat (199) @(negedge clk);
        chk("hb pre_expiry_idle", 32'(busy[1]), 32'd0);
        din[1] = 8'h6E;
        sb1.push_back(8'h6E);
        idle_until_busy(1, 50, n);
        chk("hb expiry_latency", 32'(n), 32'd1);
        measure(1, nb, spos, nsent);
        chk("hb busy_len3", 32'(nb), 32'd100);
        sb1.push_back(8'h6E);
        idle_until_busy(1, 1000, n);
        chk("hb idle_len2", 32'(n), 32'd200);
        measure(1, nb, spos, nsent);
        chk("hb busy_len4", 32'(nb), 32'd100);

        repeat (5) @(negedge clk);
        chk("sb0 drained", 32'(sb0.size()), 32'd0);
        chk("sb1 drained", 32'(sb1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
